// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the unified-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_e;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } arb_gnt_e;

    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_MAX_DATA_STREAK = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 64;

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// rtl/mem_arbiter_timeout_ctr.sv - BUSY-cycle watchdog, present only with MEM_ARB_TIMEOUT_EN
// Reloaded on every grant; expire_o flags the last permitted BUSY cycle.
`ifdef MEM_ARB_TIMEOUT_EN
module arb_timeout_ctr #(
    parameter int CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (count_i && (cnt_q != CW'(CYCLES - 1))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = count_i && (cnt_q == CW'(CYCLES - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and data access
// Optional BUSY watchdog with arb_err reporting is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_err
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    arb_state_e          state_q;
    arb_gnt_e            gnt_q;
    logic [SW-1:0]       streak_q;
    logic [SW-1:0]       streak_d;
    logic                pick_d;
    logic                expire;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [DATA_W/8-1:0] mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                if_ready_q;
    logic                d_ready_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                arb_err_q;

    // Data wins unless fetch has already watched MAX_DATA_STREAK data grants go by.
    always_comb begin
        pick_d   = d_req && !(if_req && (streak_q == SW'(MAX_DATA_STREAK)));
        streak_d = '0;
        if (pick_d && if_req) begin
            streak_d = streak_q + 1'b1;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    arb_timeout_ctr #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_q == IDLE),
        .count_i  (state_q == BUSY),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            arb_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_req || if_req) begin
                        state_q   <= BUSY;
                        mem_req_q <= 1'b1;
                        streak_q  <= streak_d;
                        if (pick_d) begin
                            gnt_q       <= GNT_D;
                            mem_we_q    <= d_we;
                            mem_be_q    <= d_we ? d_be : '1;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            gnt_q       <= GNT_IF;
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= '1;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready || expire) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        arb_err_q <= !mem_ready;
                        if (gnt_q == GNT_D) begin
                            d_ready_q <= 1'b1;
                            d_rdata_q <= mem_ready ? mem_rdata : '0;
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                // Requests are not sampled here so a still-held request is not served twice.
                RESP: begin
                    state_q    <= IDLE;
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    arb_err_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign arb_err   = arb_err_q;
    assign stall_if  = if_req && !if_ready_q;
    assign stall_mem = d_req && !d_ready_q;

endmodule
